inv_dir_dispatch: RTL and testbench

//  Issuing end of the inverse-direction divider interface. Buffers TaggedDirection words from ray setup,

---
 rtl/inv_dir_dispatch.sv | 107 ++++++++++
 tb/tb_inv_dir_dispatch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_dir_dispatch.sv
// inv_dir_dispatch: buffers tagged directions and issues them one at a time to the inverse divider cluster
module inv_dir_dispatch #(
  parameter int WIDTH = 16,
  parameter int Q_BITS = 12,
  parameter int TAG_SIZE = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 64,
  localparam int TDW = TAG_SIZE + 3 * WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [TDW-1:0] in_td,
  output logic           div_start,
  output logic [TDW-1:0] div_td,
  input  logic           div_ready,
  input  logic           div_valid,
  input  logic [TDW-1:0] div_itd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [TDW-1:0] out_itd,
  output logic           zero_fix,
  output logic           tag_err,
  output logic           timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (Q_BITS >= WIDTH) begin : g_bad_q
    $error("Q_BITS must be smaller than WIDTH");
  end
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, state_nx;
  logic [TDW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic push, pop, expired, has_zero;
  logic [TDW-1:0] head, fixed;
  assign in_ready = cnt != CW'(FIFO_DEPTH);
  assign push = in_valid && in_ready;
  assign pop = state == IDLE && cnt != '0 && !out_valid;
  assign head = mem[rp];
  assign expired = timer == TW'(TIMEOUT - 1);
  // zero components would make the divider blow up, so nudge them to one LSB
  always_comb begin
    fixed = head;
    has_zero = 1'b0;
    for (int i = 0; i < 3; i++)
      if (head[i*WIDTH +: WIDTH] == '0) begin
        fixed[i*WIDTH +: WIDTH] = WIDTH'(1);
        has_zero = 1'b1;
      end
  end
  // input buffer: ring of FIFO_DEPTH entries with an explicit occupancy count
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= in_td;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // next-state: one job in flight, abandoned if the cluster never answers
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = pop ? ISSUE : IDLE;
      ISSUE: state_nx = div_ready ? WAIT : ISSUE;
      WAIT:  state_nx = div_valid ? HOLD : expired ? IDLE : WAIT;
      HOLD:  state_nx = out_ready ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    div_start = state == ISSUE && div_ready;
    out_valid = state == HOLD;
    tag_err = state == WAIT && div_valid && div_itd[TDW-1 -: TAG_SIZE] != div_td[TDW-1 -: TAG_SIZE];
    timeout = state == WAIT && !div_valid && expired;
  end
  // operand, result and wait-timer registers
  always_ff @(posedge clk)
    if (reset) begin
      div_td <= '0;
      out_itd <= '0;
      zero_fix <= 1'b0;
      timer <= '0;
    end else begin
      zero_fix <= pop && has_zero;
      if (pop) div_td <= fixed;
      timer <= div_start ? '0 : state == WAIT ? timer + 1'b1 : timer;
      if (state == WAIT && div_valid) out_itd <= {div_td[TDW-1 -: TAG_SIZE], div_itd[3*WIDTH-1:0]};
    end
endmodule

// File: tb/tb_inv_dir_dispatch.sv
// tb_inv_dir_dispatch: directed checks of the dispatcher against a behavioural divider cluster
module tb_inv_dir_dispatch;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [55:0] in_td = '0;
  logic div_start, div_ready, div_valid;
  logic [55:0] div_td, div_itd;
  logic out_valid, out_ready = 1'b1;
  logic [55:0] out_itd;
  logic zero_fix, tag_err, timeout;
  logic mdl_valid = 1'b0, inj_valid = 1'b0;
  logic [55:0] mdl_itd = '0, inj_itd = '0;
  logic busy = 1'b0, never = 1'b0, tagp1 = 1'b0, jnever = 1'b0, jtp1 = 1'b0;
  logic [55:0] job = '0;
  int lat = 17, mcnt = 0;
  int cyc = 0, nvec = 0, nerr = 0;
  int starts = 0, start_cyc = 0, push_cyc = 0, dv_cyc = 0, ov_cyc = 0, to_cyc = 0, zf_cyc = 0;
  int zf_cnt = 0, te_cnt = 0, to_cnt = 0;
  logic ov_prev = 1'b0, saw_full = 1'b0;
  logic [55:0] last_td = '0;
  logic [55:0] got[$];

  inv_dir_dispatch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_td(in_td),
    .div_start(div_start), .div_td(div_td), .div_ready(div_ready), .div_valid(div_valid),
    .div_itd(div_itd), .out_valid(out_valid), .out_ready(out_ready), .out_itd(out_itd),
    .zero_fix(zero_fix), .tag_err(tag_err), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign div_ready = !busy;
  assign div_valid = mdl_valid | inj_valid;
  assign div_itd = inj_valid ? inj_itd : mdl_itd;

  function automatic logic [55:0] td(input logic [7:0] t, input logic [15:0] x, y, z);
    return {t, x, y, z};
  endfunction

  function automatic logic [15:0] inv16(input logic [15:0] c);
    int q;
    if (c == 16'h0) return 16'h7FFF;
    q = 16777216 / int'($signed(c));
    if (q > 32767) return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    return q[15:0];
  endfunction

  // behavioural Q3.12 reciprocal cluster with per-job latency and fault modes
  always @(posedge clk) begin
    mdl_valid <= 1'b0;
    if (reset) busy <= 1'b0;
    else if (busy) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        busy <= 1'b0;
        if (!jnever) begin
          mdl_valid <= 1'b1;
          mdl_itd <= {job[55:48] + 8'(jtp1), inv16(job[47:32]), inv16(job[31:16]), inv16(job[15:0])};
        end
      end
    end else if (div_start) begin
      busy <= 1'b1;
      mcnt <= lat;
      job <= div_td;
      jnever <= never;
      jtp1 <= tagp1;
    end
  end

  // mid-cycle monitor of handshakes and pulses
  always @(negedge clk) begin
    #2;
    if (div_start) begin starts++; start_cyc = cyc; last_td = div_td; end
    if (div_valid) dv_cyc = cyc;
    if (out_valid && !ov_prev) ov_cyc = cyc;
    ov_prev = out_valid;
    if (out_valid && out_ready) got.push_back(out_itd);
    if (zero_fix) begin zf_cnt++; zf_cyc = cyc; end
    if (tag_err) te_cnt++;
    if (timeout) begin to_cnt++; to_cyc = cyc; end
    if (!in_ready) saw_full = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [55:0] v);
    int b = 0;
    in_valid = 1'b1;
    in_td = v;
    while (!in_ready && b < 200) begin @(negedge clk); b++; end
    if (!in_ready) chk("push_stall", 64'(in_ready), 64'd1);
    push_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int b = 0;
    while (got.size() < n && b < 2000) begin @(negedge clk); b++; end
    chk("result_count", 64'(got.size()), 64'(n));
  endtask

  task automatic wait_starts(input int n);
    int b = 0;
    while (starts < n && b < 2000) begin @(negedge clk); b++; end
    chk("start_count", 64'(starts), 64'(n));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_div_start"}, 64'(div_start), 64'd0);
    chk({tag, "_div_td"}, 64'(div_td), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_itd"}, 64'(out_itd), 64'd0);
    chk({tag, "_pulses"}, 64'({zero_fix, tag_err, timeout}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, s30, bad;
    logic [55:0] snap;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    // single job
    push(td(8'd5, 16'h2000, 16'h1000, 16'hF000));
    wait_got(1);
    chk("t1_result", 64'(got[0]), 64'(td(8'd5, 16'h0800, 16'h1000, 16'hF000)));
    chk("t1_start_latency", 64'(start_cyc - push_cyc), 64'd2);
    chk("t1_out_latency", 64'(ov_cyc - dv_cyc), 64'd1);
    repeat (5) @(negedge clk);
    chk("t1_starts", 64'(starts), 64'd1);
    // burst of six
    got.delete();
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) push(td(8'(i), 16'h1000, 16'h0800, 16'h4000));
    wait_got(6);
    chk("t2_in_ready_dropped", 64'(saw_full), 64'd1);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_result%0d", i), 64'(got[i]), 64'(td(8'(i), 16'h1000, 16'h2000, 16'h0400)));
    repeat (5) @(negedge clk);
    chk("t2_starts", 64'(starts), 64'd7);
    // downstream backpressure
    got.delete();
    out_ready = 1'b0;
    lat = 2;
    for (int i = 0; i < 5; i++) push(td(8'(10 + i), 16'h1000, 16'h0800, 16'h4000));
    for (int b = 0; b < 100 && !out_valid; b++) @(negedge clk);
    chk("t3_hold_reached", 64'(out_valid), 64'd1);
    snap = out_itd;
    s0 = starts;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_itd !== snap) bad++;
    end
    chk("t3_hold_stable", 64'(bad), 64'd0);
    chk("t3_no_start", 64'(starts - s0), 64'd0);
    chk("t3_fifo_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    wait_got(5);
    for (int i = 0; i < 5; i++) chk($sformatf("t3_result%0d", i), 64'(got[i]), 64'(td(8'(10 + i), 16'h1000, 16'h2000, 16'h0400)));
    chk("t3_no_zero_fix", 64'(zf_cnt), 64'd0);
    // zero component guard
    got.delete();
    push(td(8'd20, 16'h0000, 16'h1000, 16'hF000));
    wait_got(1);
    chk("t4_zero_fix_count", 64'(zf_cnt), 64'd1);
    chk("t4_zero_fix_cycle", 64'(zf_cyc - start_cyc), 64'd0);
    chk("t4_div_td", 64'(last_td), 64'(td(8'd20, 16'h0001, 16'h1000, 16'hF000)));
    chk("t4_result", 64'(got[0]), 64'(td(8'd20, 16'h7FFF, 16'h1000, 16'hF000)));
    // timeout then tag mismatch
    got.delete();
    te_cnt = 0;
    s0 = starts;
    never = 1'b1;
    lat = 1;
    push(td(8'd30, 16'h1000, 16'h1000, 16'h1000));
    wait_starts(s0 + 1);
    s30 = start_cyc;
    never = 1'b0;
    tagp1 = 1'b1;
    lat = 3;
    push(td(8'd31, 16'h1000, 16'h1000, 16'h1000));
    wait_got(1);
    chk("t5_timeout_count", 64'(to_cnt), 64'd1);
    chk("t5_timeout_cycle", 64'(to_cyc - s30), 64'd64);
    chk("t5_tag_err_count", 64'(te_cnt), 64'd1);
    chk("t5_result", 64'(got[0]), 64'(td(8'd31, 16'h1000, 16'h1000, 16'h1000)));
    chk("t5_starts", 64'(starts - s0), 64'd2);
    tagp1 = 1'b0;
    // reset while waiting with two jobs buffered
    got.delete();
    lat = 17;
    s0 = starts;
    for (int i = 0; i < 3; i++) push(td(8'(40 + i), 16'h1000, 16'h1000, 16'h1000));
    wait_starts(s0 + 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("t6");
    reset = 1'b0;
    s0 = starts;
    inj_itd = td(8'd40, 16'h1234, 16'h5678, 16'h9ABC);
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_no_output", 64'(got.size()), 64'd0);
    chk("t6_no_start", 64'(starts - s0), 64'd0);
    push(td(8'd43, 16'h2000, 16'h1000, 16'hF000));
    wait_got(1);
    chk("t6_result", 64'(got[0]), 64'(td(8'd43, 16'h0800, 16'h1000, 16'hF000)));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
